sram_controller: RTL and testbench
==================================

# sram_controller

Responder side of the 32-bit memory request interface driven by the data cache controller. Accepts one word read or write per request and performs it as two 16-bit accesses to the external asynchronous SRAM, low halfword first, with a fixed per-halfword wait. Reports completion with a one-cycle `ready` pulse and returns the assembled read word in that cycle. Sits between the cache controller and the board SRAM pins.

## Interface
- `WAIT_CYCLES`, 2: cycles per halfword phase; legal range 1..7.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `address` in 32: byte address; bits [1:0] ignored.
- `writeData` in 32: write word.
- `readEn` in 1: read request.
- `writeEn` in 1: write request; wins over `readEn` when both are high.
- `readData` out 32: read word; valid only while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_WE_N` out 1: SRAM write enable, active low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: constant 0.

## Operation
- States: IDLE, LOW, HIGH, DONE (plus GAP, only with the macro in Configuration).
- **IDLE:**
  - If `writeEn` or `readEn` is high, latch `address`, `writeData` and op type (write if `writeEn`), clear the phase counter, and go to LOW.
  - Otherwise stay in IDLE.
  - A single-cycle enable is sufficient. An enable held high is accepted once only.
- **LOW:**
  - `SRAM_ADDR`={addr[18:2],1'b0}.
  - Write: `SRAM_DQ` drives data[15:0] and `SRAM_WE_N`=0 for the whole phase.
  - Read: `SRAM_DQ` is hi-Z and `SRAM_WE_N`=1. `SRAM_DQ` is captured into lsb[15:0] on the last phase cycle.
  - After `WAIT_CYCLES` cycles go to HIGH.
- **HIGH:**
  - Same as LOW, with `SRAM_ADDR`={addr[18:2],1'b1}, data[31:16], and capture into msb.
  - After `WAIT_CYCLES` cycles go to DONE.
- **DONE:**
  - `ready`=1.
  - `readData`={msb,lsb} for reads; unchanged from the previous read for writes.
  - `SRAM_WE_N`=1 and `SRAM_DQ` is hi-Z.
  - `readEn` and `writeEn` are ignored. Next state is always IDLE.
- Enables are ignored in every state other than IDLE. Address and data are taken only from the latched copy.
- Reset, from any state including mid-access:
  - Next state is IDLE.
  - `ready`=0, `readData`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_DQ` hi-Z.
  - Any partial write is abandoned.
- Address bits [31:19] are ignored, so the address wraps modulo 512 KB.

## Timing
- Cycle 0 is the cycle in which an enable is seen in IDLE.
- LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W, where W=`WAIT_CYCLES`.
- DONE and the `ready` pulse fall in cycle 2W+1. Default latency is 5 cycles.
- A new request is accepted at the earliest in cycle 2W+2 (IDLE). A one-cycle enable pulse there is legal and is the cache's second-fetch pattern.
- `ready` is registered (decoded from state) and never combinational from the enables.
- `SRAM_WE_N`, `SRAM_ADDR` and the `SRAM_DQ` output-enable are registered outputs. They change only at phase boundaries.

## Configuration
- `SRAM_CTRL_WE_GAP_EN`
  - Defined: writes insert one GAP cycle between LOW and HIGH, with `SRAM_WE_N`=1, DQ hi-Z and `SRAM_ADDR` held at the LOW value. Write latency becomes 2W+2. Read timing is unchanged.
  - Undefined: there is no GAP state, and reads and writes have identical latency.

## Structure
- Package `sram_pkg` holds:
  - state encoding localparams;
  - `SRAM_DATA_W`=16 and `SRAM_ADDR_W`=18;
  - the default wait constant.
- No sub-module. The phase counter (3 bits) and tristate control stay inline.

## Test plan
- Write 0xDEADBEEF to address 0x0000_0104, W=2 → LOW drives `SRAM_ADDR`=0x082, DQ=0xBEEF and WE_N=0 in cycles 1-2. HIGH drives 0x083, 0xDEAD. `ready`=1 in cycle 5 only.
- Read from 0x0000_0104, with the SRAM model holding 0x082=0x1234 and 0x083=0xABCD → `readData`=0xABCD1234 with `ready` in cycle 5. DQ is never driven by the DUT.
- Cache pattern:
  - Read with `readEn` held until `ready`.
  - Then a one-cycle `readEn` pulse to address+4 in the following cycle.
  - Required: second `ready` exactly 6 cycles after the first; both words correct.
- `readEn` and `writeEn` high together → write performed; WE_N pulses low and no read capture occurs.
- Assert `rst` in cycle 3 of a write → next cycle is IDLE, WE_N=1, DQ hi-Z, no `ready`. A subsequent read completes normally.
- With `SRAM_CTRL_WE_GAP_EN` defined: a write shows WE_N=1 in cycle 3 and `ready` in cycle 6. A read still completes in cycle 5.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the word-to-halfword SRAM controller.
package sram_pkg;

   localparam int SRAM_DATA_W         = 16;
   localparam int SRAM_ADDR_W         = 18;
   localparam int DEFAULT_WAIT_CYCLES = 2;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOW  = 3'd1;
   localparam logic [2:0] ST_HIGH = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      LOW  = ST_LOW,
      HIGH = ST_HIGH,
      DONE = ST_DONE,
      GAP  = ST_GAP
   } state_t;

endpackage

// File: rtl/sram_controller.sv
// 32-bit request responder performing each word as two 16-bit async SRAM accesses.
// Optional SRAM_CTRL_WE_GAP_EN inserts a WE_N-high gap cycle between write halves.
//
// state | meaning
// IDLE  | waiting for readEn/writeEn; request latched on acceptance
// LOW   | low halfword access, WAIT_CYCLES cycles
// GAP   | write only, one cycle with WE_N high between halves (macro builds)
// HIGH  | high halfword access, WAIT_CYCLES cycles
// DONE  | one-cycle ready pulse, readData valid
import sram_pkg::*;

module sram_controller #(
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            address,
   input  logic [31:0]            writeData,
   input  logic                   readEn,
   input  logic                   writeEn,
   output logic [31:0]            readData,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N
);

   localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic                   phase_end;

   logic                   wr_q;
   logic [16:0]            addr_q;
   logic [31:0]            data_q;
   logic [15:0]            lsb_q;
   logic [31:0]            rdata_q;

   logic                   src_wr;
   logic [16:0]            src_addr;
   logic [31:0]            src_data;

   logic [SRAM_ADDR_W-1:0] addr_out_q, addr_out_d;
   logic                   we_n_q, we_n_d;
   logic                   oe_q, oe_d;
   logic [SRAM_DATA_W-1:0] dout_q, dout_d;

   logic                   accept;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^{address[31:19], address[1:0]};
   assign accept    = (state_q == IDLE) && (writeEn || readEn);
   assign phase_end = (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      src_wr   = wr_q;
      src_addr = addr_q;
      src_data = data_q;

      case (state_q)
         IDLE: begin
            src_wr   = writeEn;
            src_addr = address[18:2];
            src_data = writeData;
            if (writeEn || readEn) begin
               state_d = LOW;
               cnt_d   = 3'd0;
            end
         end
         LOW: begin
            if (phase_end) begin
               cnt_d = 3'd0;
`ifdef SRAM_CTRL_WE_GAP_EN
               state_d = wr_q ? GAP : HIGH;
`else
               state_d = HIGH;
`endif
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
`ifdef SRAM_CTRL_WE_GAP_EN
         GAP: begin
            state_d = HIGH;
            cnt_d   = 3'd0;
         end
`endif
         HIGH: begin
            if (phase_end) begin
               state_d = DONE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pin controls are registered from the next state so they switch exactly at phase entry.
   always_comb begin
      addr_out_d = addr_out_q;
      we_n_d     = 1'b1;
      oe_d       = 1'b0;
      dout_d     = dout_q;

      case (state_d)
         LOW: begin
            addr_out_d = {src_addr, 1'b0};
            we_n_d     = ~src_wr;
            oe_d       = src_wr;
            dout_d     = src_data[15:0];
         end
         HIGH: begin
            addr_out_d = {src_addr, 1'b1};
            we_n_d     = ~src_wr;
            oe_d       = src_wr;
            dout_d     = src_data[31:16];
         end
         default: begin
            addr_out_d = addr_out_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         lsb_q      <= '0;
         rdata_q    <= '0;
         addr_out_q <= '0;
         we_n_q     <= 1'b1;
         oe_q       <= 1'b0;
         dout_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_out_q <= addr_out_d;
         we_n_q     <= we_n_d;
         oe_q       <= oe_d;
         dout_q     <= dout_d;

         if (accept) begin
            wr_q   <= writeEn;
            addr_q <= address[18:2];
            data_q <= writeData;
         end

         if ((state_q == LOW) && phase_end && !wr_q)
            lsb_q <= SRAM_DQ;

         if ((state_q == HIGH) && phase_end && !wr_q)
            rdata_q <= {SRAM_DQ, lsb_q};
      end
   end

   assign ready     = (state_q == DONE);
   assign readData  = rdata_q;
   assign SRAM_ADDR = addr_out_q;
   assign SRAM_WE_N = we_n_q;
   assign SRAM_DQ   = oe_q ? dout_q : {SRAM_DATA_W{1'bz}};
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: transaction-timeline model plus directed literal checks.
module tb_sram_controller;

   localparam int W = 2;
`ifdef SRAM_CTRL_WE_GAP_EN
   localparam int G = 1;
`else
   localparam int G = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address = '0;
   logic [31:0] writeData = '0;
   logic        readEn = 1'b0;
   logic        writeEn = 1'b0;
   wire  [31:0] readData;
   wire         ready;
   wire  [15:0] sram_dq;
   wire  [17:0] sram_addr;
   wire         we_n, ce_n, oe_n, ub_n, lb_n;

   sram_controller #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .address(address), .writeData(writeData),
      .readEn(readEn), .writeEn(writeEn), .readData(readData), .ready(ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   always #5 clk = ~clk;

   // Board SRAM: drives the bus whenever WE_N is high, stores on clock edges while WE_N is low.
   logic [15:0] sram [0:262143];
   assign sram_dq = (we_n && !oe_n) ? sram[sram_addr] : 16'hzzzz;
   always @(posedge clk) if (!we_n) sram[sram_addr] <= sram_dq;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one outstanding request, outputs derived from its cycle offset.
   logic [15:0] mm [logic [17:0]];
   logic        m_rst_prev = 1'b1;
   logic        m_busy = 1'b0;
   int          m_start = 0;
   int          m_lat = 0;
   logic        m_wr = 1'b0;
   logic [31:0] m_addr = '0;
   logic [31:0] m_data = '0;
   logic [17:0] m_hold = '0;
   logic [31:0] m_rdata = '0;

   always @(negedge clk) begin : model
      logic [17:0] lo, hi, e_addr;
      logic [15:0] e_dq;
      logic        e_ready, e_we_n;
      int          off, g;

      if (m_rst_prev) begin
         m_busy  = 1'b0;
         m_hold  = '0;
         m_rdata = '0;
      end else if (m_busy && cyc > m_start + m_lat) begin
         m_busy = 1'b0;
      end

      e_ready = 1'b0;
      e_we_n  = 1'b1;
      e_addr  = m_hold;
      e_dq    = '0;
      if (m_busy) begin
         lo  = {m_addr[18:2], 1'b0};
         hi  = {m_addr[18:2], 1'b1};
         off = cyc - m_start;
         g   = m_wr ? G : 0;
         if (off >= 1 && off <= W) begin
            e_addr = lo; e_we_n = !m_wr; e_dq = m_data[15:0];
         end else if (off >= W + 1 + g && off <= 2 * W + g) begin
            e_addr = hi; e_we_n = !m_wr; e_dq = m_data[31:16];
         end else if (off == 2 * W + 1 + g) begin
            e_ready = 1'b1;
            if (!m_wr) m_rdata = {mm[hi], mm[lo]};
         end
      end
      m_hold = e_addr;
      if (!e_we_n) mm[e_addr] = e_dq;

      chk("ready", {31'd0, ready}, {31'd0, e_ready});
      chk("we_n", {31'd0, we_n}, {31'd0, e_we_n});
      chk("sram_addr", {14'd0, sram_addr}, {14'd0, e_addr});
      if (e_ready) chk("read_data", readData, m_rdata);
      if (!e_we_n) chk("dq_write", {16'd0, sram_dq}, {16'd0, e_dq});
      else         chk("dq_bus", {16'd0, sram_dq}, {16'd0, sram[sram_addr]});
      chk("ctl_const", {28'd0, ce_n, oe_n, ub_n, lb_n}, 32'd0);

      if (!rst && !m_busy && (readEn || writeEn)) begin
         m_busy  = 1'b1;
         m_start = cyc;
         m_wr    = writeEn;
         m_addr  = address;
         m_data  = writeData;
         m_lat   = 2 * W + 1 + (writeEn ? G : 0);
      end
      m_rst_prev = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata);
      tick();
      writeEn = wr; readEn = rd; address = a; writeData = d;
      lat = -1;
      rdata = '0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) begin writeEn = 1'b0; readEn = 1'b0; end
         @(negedge clk);
         if (ready && lat < 0) begin lat = k; rdata = readData; end
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          lat, t1, t2;
      logic [31:0] rd, d1, d2, r;

      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      chk("rst_rdata", readData, 32'd0);

      // Write 0xDEADBEEF to 0x104, per-cycle pin checks
      tick();
      writeEn = 1'b1; address = 32'h0000_0104; writeData = 32'hDEAD_BEEF;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) writeEn = 1'b0;
         @(negedge clk);
         if (k <= 2) begin
            chk("t1_addr_lo", {14'd0, sram_addr}, 32'h082);
            chk("t1_dq_lo", {16'd0, sram_dq}, 32'hBEEF);
            chk("t1_we_lo", {31'd0, we_n}, 32'd0);
         end
`ifdef SRAM_CTRL_WE_GAP_EN
         else if (k == 3) begin
            chk("t1_gap_we", {31'd0, we_n}, 32'd1);
            chk("t1_gap_addr", {14'd0, sram_addr}, 32'h082);
         end
`endif
         else if (k <= 4 + G) begin
            chk("t1_addr_hi", {14'd0, sram_addr}, 32'h083);
            chk("t1_dq_hi", {16'd0, sram_dq}, 32'hDEAD);
            chk("t1_we_hi", {31'd0, we_n}, 32'd0);
         end
         chk("t1_ready", {31'd0, ready}, {31'd0, (k == 5 + G)});
      end

      // Store 0xABCD1234 at 0x104 and read it back
      run_op(1'b1, 1'b0, 32'h0000_0104, 32'hABCD_1234, lat, rd);
      chk("t2_write_lat", lat, 5 + G);
      run_op(1'b0, 1'b1, 32'h0000_0104, 32'h0, lat, rd);
      chk("t2_read_lat", lat, 5);
      chk("t2_read_data", rd, 32'hABCD_1234);

      // Both enables: write wins, readData holds the previous read word
      run_op(1'b1, 1'b1, 32'h0000_0200, 32'h0F0F_F0F0, lat, rd);
      chk("t3_both_lat", lat, 5 + G);
      chk("t3_rdata_hold", rd, 32'hABCD_1234);
      run_op(1'b0, 1'b1, 32'h0000_0200, 32'h0, lat, rd);
      chk("t3_readback", rd, 32'h0F0F_F0F0);

      // Cache pattern: held readEn, then one-cycle pulse to address+4
      run_op(1'b1, 1'b0, 32'h0000_0108, 32'h55AA_1357, lat, rd);
      tick();
      readEn = 1'b1; address = 32'h0000_0104;
      t1 = -1; t2 = -1; d1 = '0; d2 = '0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (t1 >= 0 && k == t1 + 1) begin address = 32'h0000_0108; readEn = 1'b1; end
         else if (t1 >= 0) readEn = 1'b0;
         @(negedge clk);
         if (ready) begin
            if (t1 < 0) begin t1 = k; d1 = readData; end
            else if (t2 < 0) begin t2 = k; d2 = readData; end
         end
      end
      readEn = 1'b0;
      chk("t4_first_lat", t1, 5);
      chk("t4_ready_spacing", t2 - t1, 6);
      chk("t4_word0", d1, 32'hABCD_1234);
      chk("t4_word1", d2, 32'h55AA_1357);

      // Reset asserted in cycle 3 of a write
      tick();
      writeEn = 1'b1; address = 32'h0000_0300; writeData = 32'h1111_2222;
      tick(); writeEn = 1'b0;
      tick();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("t5_we_n", {31'd0, we_n}, 32'd1);
      chk("t5_ready", {31'd0, ready}, 32'd0);
      chk("t5_addr", {14'd0, sram_addr}, 32'd0);
      chk("t5_rdata", readData, 32'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         @(negedge clk);
         chk("t5_no_ready", {31'd0, ready}, 32'd0);
      end
      run_op(1'b0, 1'b1, 32'h0000_0104, 32'h0, lat, rd);
      chk("t5_read_lat", lat, 5);
      chk("t5_read_data", rd, 32'hABCD_1234);

      // Random traffic over a small pool with aliased upper address bits
      for (int i = 0; i < 8; i++) begin
         r = $urandom();
         run_op(1'b1, 1'b0, (r & 32'hFFF8_0003) | (32'h0000_2000 + 32'(i * 4)), $urandom(), lat, rd);
      end
      for (int n = 0; n < 3000; n++) begin
         int sel;
         tick();
         r         = $urandom();
         sel       = $urandom_range(0, 9);
         rst       = ($urandom_range(0, 149) == 0);
         readEn    = (sel < 3);
         writeEn   = (sel >= 2 && sel < 5);
         address   = (r & 32'hFFF8_0003) | (32'h0000_2000 + 32'($urandom_range(0, 7) * 4));
         writeData = $urandom();
      end
      tick();
      rst = 1'b0; readEn = 1'b0; writeEn = 1'b0;
      repeat (12) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
